// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//
// Adds (or subtracts) two WIDTH-bit operands CHUNK bits at a time. Stage k
// adds chunk k using the carry registered by stage k-1, then registers the
// partial sum collected so far, its carry, and the operand chunks that are
// still unprocessed. The last stage register is the output register, so a
// result appears STAGES = WIDTH/CHUNK cycles after its operands are accepted.
// WIDTH must be an integer multiple of CHUNK.
//
// Optional feature: define PIPELINED_ADDER_FLAGS_EN to add the registered
// zf / sf / of flag outputs. Without it those ports and their logic are absent.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand set present
//   in_ready   block accepts the operand set this cycle
//   a, b       operands (WIDTH bits)
//   c_in       carry-in, used only when sub = 0
//   sub        1 = a - b, 0 = a + b
//   out_valid  result present
//   out_ready  consumer takes the result this cycle
//   sum        result (WIDTH bits)
//   c_out      carry out of bit WIDTH-1 (for sub = 1, 1 means no borrow)
//   zf, sf, of zero / sign / signed-overflow flags (PIPELINED_ADDER_FLAGS_EN)
//
// Handshake: an operand set transfers on a rising edge where
// in_valid && in_ready; a result transfers where out_valid && out_ready.
// in_valid/out_valid never depend on the matching ready. All stages advance
// together whenever the output register is empty or being drained
// (adv = !out_valid || out_ready), and in_ready is exactly adv (forced low
// during reset). Empty cycles travel down the pipe as stages with v_q = 0.
// ---------------------------------------------------------------------------
module pipelined_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef PIPELINED_ADDER_FLAGS_EN
  ,
  output logic             zf,
  output logic             sf,
  output logic             of
`endif
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             adv;
  logic [WIDTH-1:0] bx_in;   // B' : b or ~b
  logic             cin_in;  // cin' : c_in, or 1 for subtraction

  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv && !rst;
    bx_in    = sub ? ~b : b;
    cin_in   = sub ? 1'b1 : c_in;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * CHUNK;  // sum bits known after this stage
    localparam int REM  = WIDTH - DONE;     // operand bits still to be added

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             cy_src;
    logic             v_src;
    logic [CHUNK:0]   chunk_sum;
    logic [DONE-1:0]  s_d;
    logic [DONE-1:0]  s_q;
    logic             cy_d;
    logic             cy_q;
    logic             v_d;
    logic             v_q;

    if (k == 0) begin : g_src
      always_comb begin
        a_chunk = a[CHUNK-1:0];
        b_chunk = bx_in[CHUNK-1:0];
        cy_src  = cin_in;
        v_src   = in_valid && in_ready;
        s_d     = chunk_sum[CHUNK-1:0];
      end
    end else begin : g_src
      always_comb begin
        a_chunk = g_stage[k-1].g_rem.ra_q[CHUNK-1:0];
        b_chunk = g_stage[k-1].g_rem.rb_q[CHUNK-1:0];
        cy_src  = g_stage[k-1].cy_q;
        v_src   = g_stage[k-1].v_q;
        s_d     = {chunk_sum[CHUNK-1:0], g_stage[k-1].s_q};
      end
    end

    always_comb begin
      chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cy_src};
      cy_d      = chunk_sum[CHUNK];
      v_d       = v_src;
    end

    // Data is loaded even for bubbles; only v_q says whether it means anything.
    always_ff @(posedge clk) begin
      if (rst) begin
        s_q  <= '0;
        cy_q <= 1'b0;
        v_q  <= 1'b0;
      end else if (adv) begin
        s_q  <= s_d;
        cy_q <= cy_d;
        v_q  <= v_d;
      end
    end

    // Unprocessed upper operand chunks; the last stage has none left.
    if (REM > 0) begin : g_rem
      logic [REM-1:0] ra_d;
      logic [REM-1:0] ra_q;
      logic [REM-1:0] rb_d;
      logic [REM-1:0] rb_q;

      if (k == 0) begin : g_rsrc
        always_comb begin
          ra_d = a[WIDTH-1:DONE];
          rb_d = bx_in[WIDTH-1:DONE];
        end
      end else begin : g_rsrc
        always_comb begin
          ra_d = g_stage[k-1].g_rem.ra_q[REM+CHUNK-1:CHUNK];
          rb_d = g_stage[k-1].g_rem.rb_q[REM+CHUNK-1:CHUNK];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (adv) begin
          ra_q <= ra_d;
          rb_q <= rb_d;
        end
      end
    end
  end

  always_comb begin
    sum       = g_stage[STAGES-1].s_q;
    c_out     = g_stage[STAGES-1].cy_q;
    out_valid = g_stage[STAGES-1].v_q;
  end

`ifdef PIPELINED_ADDER_FLAGS_EN
  // The last stage adds the top chunk, so its chunk MSBs are A[WIDTH-1] and
  // B'[WIDTH-1]; flags are computed from the final sum before it is
  // registered, keeping them aligned with sum.
  logic zf_d, zf_q;
  logic sf_d, sf_q;
  logic of_d, of_q;

  always_comb begin
    zf_d = (g_stage[STAGES-1].s_d == '0);
    sf_d = g_stage[STAGES-1].s_d[WIDTH-1];
    of_d = (g_stage[STAGES-1].a_chunk[CHUNK-1] == g_stage[STAGES-1].b_chunk[CHUNK-1])
        && (g_stage[STAGES-1].s_d[WIDTH-1] != g_stage[STAGES-1].a_chunk[CHUNK-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (adv) begin
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  always_comb begin
    zf = zf_q;
    sf = sf_q;
    of = of_q;
  end
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
//
// Main DUT: WIDTH=64, CHUNK=16 (latency 4). Two extra DUTs (8/8 and 8/2)
// cover the small-width parameter sweep. Inputs change at the falling edge;
// all sampling happens 4 time units after the falling edge, away from the
// rising edge. Expected results come from a whole-width reference model.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // ---------------- main DUT signals ----------------
  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out;
  logic [63:0] a, b, sum;
  logic [2:0]  m_flags;

  // ---------------- sweep DUT signals ----------------
  logic       s_valid, s_cin, s_sub, s_ordy;
  logic [7:0] s_a, s_b;
  logic       x_ready, x_valid, x_cout;
  logic [7:0] x_sum;
  logic [2:0] x_flags;
  logic       y_ready, y_valid, y_cout;
  logic [7:0] y_sum;
  logic [2:0] y_flags;

`ifdef PIPELINED_ADDER_FLAGS_EN
  logic zf, sf, of, x_zf, x_sf, x_of, y_zf, y_sf, y_of;
  assign m_flags = {of, sf, zf};
  assign x_flags = {x_of, x_sf, x_zf};
  assign y_flags = {y_of, y_sf, y_zf};
`else
  assign m_flags = 3'b000;
  assign x_flags = 3'b000;
  assign y_flags = 3'b000;
`endif

  pipelined_adder #(.WIDTH(64), .CHUNK(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out)
`ifdef PIPELINED_ADDER_FLAGS_EN
    , .zf(zf), .sf(sf), .of(of)
`endif
  );

  pipelined_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(x_ready),
    .a(s_a), .b(s_b), .c_in(s_cin), .sub(s_sub),
    .out_valid(x_valid), .out_ready(s_ordy), .sum(x_sum), .c_out(x_cout)
`ifdef PIPELINED_ADDER_FLAGS_EN
    , .zf(x_zf), .sf(x_sf), .of(x_of)
`endif
  );

  pipelined_adder #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(y_ready),
    .a(s_a), .b(s_b), .c_in(s_cin), .sub(s_sub),
    .out_valid(y_valid), .out_ready(s_ordy), .sum(y_sum), .c_out(y_cout)
`ifdef PIPELINED_ADDER_FLAGS_EN
    , .zf(y_zf), .sf(y_sf), .of(y_of)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_out = 0;
  bit lat_en = 1'b0;

  logic [67:0] exp_q[$];
  int          acc_q[$];
  bit          lat_q[$];
  logic [67:0] xa_q[$];
  logic [67:0] xb_q[$];

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Packed result: {of, sf, zf, c_out, sum[63:0]}
  function automatic logic [67:0] ref_model(input int w, input logic [63:0] av,
                                            input logic [63:0] bv, input logic cv,
                                            input logic sv);
    logic [63:0] mask, am, bx, s;
    logic [64:0] t;
    logic        co, fz, fs, fo;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = av & mask;
    bx   = (sv ? ~bv : bv) & mask;
    t    = {1'b0, am} + {1'b0, bx} + {64'd0, (sv ? 1'b1 : cv)};
    s    = t[63:0] & mask;
    co   = t[w];
    fz   = (s == 64'd0);
    fs   = s[w-1];
    fo   = (am[w-1] == bx[w-1]) && (s[w-1] != am[w-1]);
`ifndef PIPELINED_ADDER_FLAGS_EN
    fz = 1'b0;
    fs = 1'b0;
    fo = 1'b0;
`endif
    return {fo, fs, fz, co, s};
  endfunction

  function automatic logic [67:0] pack(input logic [2:0] f, input logic co, input logic [63:0] s);
    return {f, co, s};
  endfunction

  // Main DUT monitor
  always @(negedge clk) begin
    #4;
    cyc++;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      lat_q.delete();
      check("rst_in_ready", in_ready, 0);
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stale_out_valid", out_valid, 0);
        end else if (!out_ready) begin
          check("hold_result", pack(m_flags, c_out, sum), exp_q[0]);
          check("stall_in_ready", in_ready, 0);
        end else begin
          check("result", pack(m_flags, c_out, sum), exp_q[0]);
          if (lat_q[0]) check("latency", cyc - acc_q[0], 4);
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          void'(lat_q.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(64, a, b, c_in, sub));
        acc_q.push_back(cyc);
        lat_q.push_back(lat_en);
      end
    end
  end

  // Sweep DUT monitor (out_ready held high for both)
  always @(negedge clk) begin
    #4;
    if (rst) begin
      xa_q.delete();
      xb_q.delete();
    end else begin
      if (x_valid) begin
        if (xa_q.size() == 0) check("w8c8_stale", x_valid, 0);
        else check("w8c8_result", pack(x_flags, x_cout, {56'd0, x_sum}), xa_q.pop_front());
      end
      if (y_valid) begin
        if (xb_q.size() == 0) check("w8c2_stale", y_valid, 0);
        else check("w8c2_result", pack(y_flags, y_cout, {56'd0, y_sum}), xb_q.pop_front());
      end
      if (s_valid && x_ready) xa_q.push_back(ref_model(8, {56'd0, s_a}, {56'd0, s_b}, s_cin, s_sub));
      if (s_valid && y_ready) xb_q.push_back(ref_model(8, {56'd0, s_a}, {56'd0, s_b}, s_cin, s_sub));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic cv, input logic sv);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = av;
    b = bv;
    c_in = cv;
    sub = sv;
    #4;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (n >= 200) check("accept_timeout", in_ready, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c_in = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Directed vectors: a, b, c_in, sub
  logic [63:0] d_a[8]   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000,
                            64'h0000_0000_0000_FFFF, 64'h0000_FFFF_FFFF_FFFF, 64'd3,
                            64'd10, 64'h7FFF_FFFF_FFFF_FFFF};
  logic [63:0] d_b[8]   = '{64'd1, 64'd7, 64'd1, 64'd1, 64'd1, 64'd4, 64'd3, 64'd1};
  logic        d_cin[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        d_sub[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    c_in = 1'b0;
    sub = 1'b0;
    out_ready = 1'b1;
    s_valid = 1'b0;
    s_a = '0;
    s_b = '0;
    s_cin = 1'b0;
    s_sub = 1'b0;
    s_ordy = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #4;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_c_out", c_out, 0);
    check("reset_flags", m_flags, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);

    // Directed single operations with latency checks
    lat_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(d_a[i], d_b[i], d_cin[i], d_sub[i]);
      idle();
      drain();
    end
    lat_en = 1'b0;

    // 10 back-to-back adds with out_ready low for three cycles
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++) send(64'(i), 64'(i), 1'b0, 1'b0);
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check("burst_count", n_out - n0, 10);

    // Random operands with random backpressure
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send({$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle();
      end
      begin
        repeat (60) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
    check("random_count", n_out - n0, 40);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) send(64'(100 + i), 64'(i), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #4;
    check("ready_after_midreset", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      check("midreset_out_valid", out_valid, 0);
      @(negedge clk);
      #4;
    end
    lat_en = 1'b1;
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    idle();
    drain();
    lat_en = 1'b0;

    // Parameter sweep on the 8-bit instances
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      s_valid = ($urandom_range(0, 3) != 0);
      s_a = 8'($urandom_range(0, 255));
      s_b = 8'($urandom_range(0, 255));
      s_cin = 1'($urandom_range(0, 1));
      s_sub = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while ((xa_q.size() != 0 || xb_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("w8c8_drain", xa_q.size(), 0);
    check("w8c2_drain", xb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 16, bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 SHALL derive STAGES = WIDTH/CHUNK, default 4.
REQ-004 Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts the operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in, used when sub=0.
- sub  input  1  1 = A minus B, 0 = A plus B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result this cycle.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of bit WIDTH-1.
- zf, sf, of  output  1 each  zero, sign and signed-overflow flags (present only per REQ-020).

Function
REQ-005 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-006 SHALL compute sum = A + B' + cin' modulo 2^WIDTH, where B' = b and cin' = c_in when sub=0, and B' = ~b and cin' = 1 when sub=1 (c_in ignored).
REQ-007 SHALL have stage k (k = 0..STAGES-1) add chunk k of A and B' with the carry registered from stage k-1 (cin' for k=0), then register the chunk result, the carry and the unprocessed upper chunks.
REQ-008 SHALL present the result with out_valid high exactly STAGES cycles after acceptance when not stalled.
REQ-009 SHALL set c_out to the raw carry out of the top chunk; for sub=1, c_out=1 means no borrow.
REQ-010 SHALL advance all stages together under one enable: adv = !out_valid || out_ready.
REQ-011 SHALL drive in_ready = adv, combinationally.
REQ-012 SHALL let bubbles (cycles with no transfer) travel as invalid entries, with a valid bit per stage.
REQ-013 SHALL keep sum, c_out, flags and out_valid stable while out_valid && !out_ready.
REQ-014 SHALL sustain one accepted input per cycle when out_ready is held high, keeping results in order.
REQ-015 SHALL, when input and output transfer in the same cycle on a full pipeline, accept the new input and retire the oldest result with no loss.
REQ-016 SHALL take the per-operation sub and c_in values only at acceptance; later input changes SHALL NOT affect operations already in flight.

Reset
REQ-017 SHALL, on rst high at a clock edge, clear every stage valid bit and drive out_valid=0, sum=0, c_out=0, zf=0, sf=0, of=0.
REQ-018 SHALL discard all in-flight operations when rst asserts mid-operation, with no result emitted afterwards.
REQ-019 SHALL drive in_ready=0 while rst is high, and in_ready=1 in the first cycle after reset.

Configuration
REQ-020 SHALL compile in zf, sf and of when macro PIPELINED_ADDER_FLAGS_EN is defined:
- zf = (sum == 0).
- sf = sum[WIDTH-1].
- of = (A[WIDTH-1] == B'[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]).
- All three are registered alongside sum.
REQ-021 SHALL omit the zf, sf and of ports and their logic entirely when PIPELINED_ADDER_FLAGS_EN is undefined; sum and c_out SHALL be unchanged.

Verification
REQ-022 Add wrap: a=0xFFFFFFFFFFFFFFFF, b=1, c_in=0, sub=0 -> sum=0, c_out=1, zf=1, of=0, out_valid at cycle 4.
REQ-023 Subtract: a=5, b=7, sub=1 -> sum=0xFFFFFFFFFFFFFFFE, c_out=0, sf=1, of=0; a=0x8000000000000000, b=1, sub=1 -> sum=0x7FFFFFFFFFFFFFFF, of=1.
REQ-024 Chunk carry chain: a=0x000000000000FFFF, b=1, sub=0 -> sum=0x0000000000010000; a=0x0000FFFFFFFFFFFF, b=1, sub=0 -> sum=0x0001000000000000.
REQ-025 Throughput and backpressure: 10 back-to-back adds (i + i), out_ready low for cycles 6-8 -> in_ready low on those cycles, held output stable, all 10 results in order, no duplicates.
REQ-026 Reset mid-flight: accept 3 operations, assert rst for 1 cycle -> out_valid stays 0 and no stale result appears; a new operation afterwards completes in 4 cycles.
REQ-027 Parameter sweep: WIDTH=8 with CHUNK=8 (latency 1) and WIDTH=8 with CHUNK=2 (latency 4) -> results match a reference model over 1000 random operands, both with and without PIPELINED_ADDER_FLAGS_EN.
